tetris_ctrl_gen: RTL and testbench
==================================

# tetris_ctrl_gen

Command generator that sits directly upstream of the tetris game core and drives its 3-bit `ctrl` input. It conditions five raw push-buttons and adds an adjustable gravity tick. The resulting requests are merged into sticky pending bits and issued one at a time as single-cycle command codes. Consecutive commands are separated by an enforced idle gap, so the core is back in its wait state before the next code arrives.

## Interface
- `DEBOUNCE`, 1_000_000: cycles a synchronized button level must be stable before it is accepted.
- `REPEAT_DELAY`, 25_000_000: hold time before left/right auto-repeat starts.
- `REPEAT_RATE`, 8_000_000: auto-repeat period for left/right.
- `GRAVITY_BASE`, 100_000_000: gravity period at level 0.
- `GAP`, 64: zero cycles forced after every issued code. Must be at least 48, which covers a full hard drop.
- `clk` input 1: the single clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `btn` input 5: raw, asynchronous buttons, active-high. [0]=hold, [1]=rotate, [2]=left, [3]=right, [4]=hard drop.
- `gravity_en` input 1: enables gravity ticks.
- `level` input 3: gravity speed select.
- `ctrl` output 3: registered command code to the core. 0=none, 1=HOLD, 2=ROTATE, 3=LEFT, 4=RIGHT, 5=DOWN, 6=BAR.
- `busy` output 1: high when the FSM is not in IDLE.

## Operation
- **Button conditioning (per button):**
  - 2-FF synchronizer.
  - Debounce: the accepted level changes only after the synchronized level differs from it for `DEBOUNCE` consecutive cycles. The counter resets on any bounce.
  - A rising edge of the accepted level produces a one-cycle request.
- **Auto-repeat (left/right only):** while the accepted level stays high, a repeat request fires `REPEAT_DELAY` cycles after the edge, then every `REPEAT_RATE` cycles. It stops when the level falls.
- **Gravity:**
  - Period P = `GRAVITY_BASE >> level`.
  - The counter counts only while `gravity_en`=1. It produces a DOWN request when count ≥ P-1, then restarts at 0.
  - If `level` rises mid-count so that count ≥ new P-1, the tick fires on the next cycle.
  - When `gravity_en`=0 the counter is held at 0.
- **Pending bits** (6 bits: HOLD, BAR, ROTATE, LEFT, RIGHT, DOWN):
  - Any request sets its bit. Requests already pending merge into the one bit.
  - The bit clears in the cycle its code is issued. A new request arriving in that same cycle wins, and the bit stays set.
- **Issue priority:** HOLD > BAR > ROTATE > LEFT > RIGHT > DOWN.
- **Issuing BAR** also clears pending DOWN and restarts the gravity counter.
- **FSM states:** IDLE, ISSUE, GAP.
  - IDLE: `ctrl`=0. If any pending bit is set, go to ISSUE and register the highest-priority code into `ctrl`.
  - ISSUE: `ctrl`=code for exactly one cycle. Clear that pending bit, load the gap counter, go to GAP.
  - GAP: `ctrl`=0 for `GAP` cycles, then go to IDLE.
- **Reset values:** all outputs and internal state are 0, FSM is in IDLE, and the accepted button levels are 0.
- **Reset mid-operation:**
  - Asserting `reset_n`=0 forces `ctrl`=0 asynchronously and discards all pending requests and counters.
  - A button held through reset release produces a request after `DEBOUNCE` cycles.

## Timing
- Raw button to request: 2 sync cycles + `DEBOUNCE` cycles + 1 edge cycle.
- Pending bit visible in IDLE → `ctrl` shows the code on the next clock edge.
- Minimum spacing between two nonzero `ctrl` codes: GAP+2 cycles (ISSUE + GAP + IDLE).
- `ctrl` is never nonzero on two consecutive cycles.
- `busy` is combinational from the FSM state register.

## Structure
- `tetris_pkg` holds:
  - the ctrl code enum (`CTRL_NONE`…`CTRL_BAR`), shared with the game core;
  - the FSM state typedef;
  - the priority order constant.
- Sub-module `tetris_btn_cond`, instantiated 5×:
  - contains the synchronizer, debounce, edge detect and optional auto-repeat;
  - parameters: `DEBOUNCE`, `REPEAT_EN`, `REPEAT_DELAY`, `REPEAT_RATE`;
  - outputs: `req` (one-cycle pulse) and `level`.
- Counter widths use `$clog2` of their parameter + 1.

## Test plan
Bench parameters: DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_RATE=6, GRAVITY_BASE=64, GAP=8.

- **Single press:** btn[1] held high → `ctrl`=2 for exactly 1 cycle, 8 cycles after the raw rise (2+4+1+1). No further code while it stays held.
- **Bounce:** btn[2] toggled every 2 cycles for 20 cycles, then held → exactly one `ctrl`=3, then repeats every 8+2=10 cycles. The effective repeat period is max(6, GAP+2).
- **Simultaneous press:** btn[0], btn[3] and btn[4] rise in the same cycle → codes 1, 6, 4 in that order, spaced exactly 10 cycles apart.
- **Gravity:** `gravity_en`=1, level=0 → `ctrl`=5 every 64 cycles. Setting level=3 mid-count at count 20 gives a tick on the next cycle, then one every 8 cycles.
- **Merge:** with `gravity_en`=1 and level=7, three DOWN ticks occur during one GAP → only one `ctrl`=5 is issued after the gap.
- **Reset:** `reset_n` pulsed low while ISSUE is driving `ctrl`=2 → `ctrl`=0 immediately, `busy`=0, and nothing is issued after release until a new press.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the tetris command path: ctrl codes seen by the game
// core, the command FSM states and the issue priority order.
package tetris_pkg;

    typedef enum logic [2:0] {
        CTRL_NONE   = 3'd0,
        CTRL_HOLD   = 3'd1,
        CTRL_ROTATE = 3'd2,
        CTRL_LEFT   = 3'd3,
        CTRL_RIGHT  = 3'd4,
        CTRL_DOWN   = 3'd5,
        CTRL_BAR    = 3'd6
    } ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } fsm_state_e;

    localparam int PEND_HOLD   = 0;
    localparam int PEND_BAR    = 1;
    localparam int PEND_ROTATE = 2;
    localparam int PEND_LEFT   = 3;
    localparam int PEND_RIGHT  = 4;
    localparam int PEND_DOWN   = 5;

    // Pending bit i issues code PRIO[i]; a lower index wins.
    localparam logic [5:0][2:0] PRIO = {CTRL_DOWN, CTRL_RIGHT, CTRL_LEFT,
                                        CTRL_ROTATE, CTRL_BAR, CTRL_HOLD};

    function automatic logic [2:0] pick_code(input logic [5:0] pend);
        pick_code = CTRL_NONE;
        for (int i = 5; i >= 0; i--) begin
            if (pend[i]) pick_code = PRIO[i];
        end
    endfunction

endpackage

// File: rtl/tetris_btn_cond.sv
// One push-button: 2-FF synchronizer, debounce, rising-edge request and an
// optional hold-to-repeat stream.
module tetris_btn_cond #(
    parameter int DEBOUNCE     = 1_000_000,
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 8_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic req,
    output logic level
);
    localparam int DW   = $clog2(DEBOUNCE) + 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;

    logic [1:0]    sync;
    logic [DW-1:0] db_cnt;
    logic          level_d;
    logic [RW-1:0] rpt_cnt;
    logic          edge_req;
    logic          rpt_req;

    assign edge_req = level & ~level_d;
    assign rpt_req  = REPEAT_EN && level && level_d && (rpt_cnt == '0);
    assign req      = edge_req | rpt_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync    <= '0;
            db_cnt  <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
            rpt_cnt <= '0;
        end else begin
            sync    <= {sync[0], btn};
            level_d <= level;
            if (sync[1] == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE - 1)) begin
                level  <= sync[1];
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DW'(1);
            end
            // Repeat timer runs only while held; first fire after the delay, then at the rate.
            if (!REPEAT_EN || !level) begin
                rpt_cnt <= '0;
            end else if (edge_req) begin
                rpt_cnt <= RW'(REPEAT_DELAY - 1);
            end else if (rpt_cnt == '0) begin
                rpt_cnt <= RW'(REPEAT_RATE - 1);
            end else begin
                rpt_cnt <= rpt_cnt - RW'(1);
            end
        end
    end

endmodule

// File: rtl/tetris_ctrl_gen.sv
// Turns buttons and a gravity tick into single-cycle ctrl codes for the game
// core, one at a time, each followed by a forced idle gap.
module tetris_ctrl_gen
    import tetris_pkg::*;
#(
    parameter int DEBOUNCE     = 1_000_000,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 8_000_000,
    parameter int GRAVITY_BASE = 100_000_000,
    parameter int GAP          = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] btn,
    input  logic       gravity_en,
    input  logic [2:0] level,
    output logic [2:0] ctrl,
    output logic       busy
);
    localparam int GW = $clog2(GRAVITY_BASE) + 1;
    localparam int CW = $clog2(GAP) + 1;

    logic [4:0]    btn_req;
    logic [4:0]    unused_btn_level;
    logic [5:0]    req_vec, pending, clr;
    logic [GW-1:0] grav_cnt, grav_period;
    logic          grav_tick, bar_issue;
    logic [CW-1:0] gap_cnt, gap_nxt;
    logic [2:0]    ctrl_nxt;
    fsm_state_e    state, state_nxt;

    for (genvar i = 0; i < 5; i++) begin : g_btn
        tetris_btn_cond #(
            .DEBOUNCE    (DEBOUNCE),
            .REPEAT_EN   ((i == 2) || (i == 3)),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_cond (
            .clk    (clk),
            .reset_n(reset_n),
            .btn    (btn[i]),
            .req    (btn_req[i]),
            .level  (unused_btn_level[i])
        );
    end

    always_comb begin
        req_vec              = '0;
        req_vec[PEND_HOLD]   = btn_req[0];
        req_vec[PEND_ROTATE] = btn_req[1];
        req_vec[PEND_LEFT]   = btn_req[2];
        req_vec[PEND_RIGHT]  = btn_req[3];
        req_vec[PEND_BAR]    = btn_req[4];
        req_vec[PEND_DOWN]   = grav_tick;
    end

    // Compare against the live period so a level increase mid-count fires at once.
    assign grav_period = GW'(GRAVITY_BASE) >> level;
    assign grav_tick   = gravity_en && ((grav_cnt + GW'(1)) >= grav_period);
    assign busy        = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        ctrl_nxt  = CTRL_NONE;
        gap_nxt   = gap_cnt;
        clr       = '0;
        bar_issue = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|pending) begin
                    state_nxt = ST_ISSUE;
                    ctrl_nxt  = pick_code(pending);
                end
            end
            ST_ISSUE: begin
                for (int i = 0; i < 6; i++) begin
                    if (ctrl == PRIO[i]) clr[i] = 1'b1;
                end
                if (ctrl == CTRL_BAR) begin
                    clr[PEND_DOWN] = 1'b1;
                    bar_issue      = 1'b1;
                end
                gap_nxt   = CW'(GAP - 1);
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_nxt = ST_IDLE;
                else               gap_nxt   = gap_cnt - CW'(1);
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ctrl     <= CTRL_NONE;
            gap_cnt  <= '0;
            pending  <= '0;
            grav_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ctrl     <= ctrl_nxt;
            gap_cnt  <= gap_nxt;
            pending  <= (pending & ~clr) | req_vec;
            if (!gravity_en || grav_tick || bar_issue) grav_cnt <= '0;
            else                                       grav_cnt <= grav_cnt + GW'(1);
        end
    end

endmodule

// File: tb/tb_tetris_ctrl_gen.sv
// Directed bench for tetris_ctrl_gen with a cycle-level behavioural model and
// hand-computed timing checks.
module tb_tetris_ctrl_gen;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 6;
    localparam int GB = 64;
    localparam int GP = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] btn;
    logic       gravity_en;
    logic [2:0] level;
    logic [2:0] ctrl;
    logic       busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    tetris_ctrl_gen #(
        .DEBOUNCE    (DB),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE (RR),
        .GRAVITY_BASE(GB),
        .GAP         (GP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn       (btn),
        .gravity_en(gravity_en),
        .level     (level),
        .ctrl      (ctrl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model state: values valid during the current cycle.
    int s1[5], s2[5], run[5], age[5];
    bit acc[5];
    bit pend[7];
    int g_cnt   = 0;
    int m_code  = 0;
    int idle_at = 0;
    bit m_busy  = 1'b0;
    int prio_list[6] = '{1, 6, 2, 3, 4, 5};
    int btn_code[5]  = '{1, 2, 3, 4, 6};

    int log_cyc[$];
    int log_code[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    function automatic int count_codes(input int code, input int from, input int upto);
        int n = 0;
        for (int k = 0; k < log_cyc.size(); k++) begin
            if (log_cyc[k] >= from && log_cyc[k] <= upto && (code == 0 || log_code[k] == code))
                n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            s1[i] = 0; s2[i] = 0; run[i] = 0; age[i] = 0; acc[i] = 1'b0;
        end
        for (int c = 0; c < 7; c++) pend[c] = 1'b0;
        g_cnt = 0; m_code = 0; idle_at = 0; m_busy = 1'b0;
    endtask

    task automatic model_step(input int t);
        bit req[5];
        bit tick;
        bit old;
        int nxt;
        for (int i = 0; i < 5; i++)
            req[i] = acc[i] && (age[i] == 0 ||
                     ((i == 2 || i == 3) && age[i] >= RD && (age[i] - RD) % RR == 0));
        tick = gravity_en && (g_cnt >= (GB >> level) - 1);
        nxt = 0;
        if (!m_busy) begin
            for (int k = 5; k >= 0; k--)
                if (pend[prio_list[k]]) nxt = prio_list[k];
        end
        if (nxt != 0) idle_at = t + GP + 2;
        if (m_code != 0) begin
            pend[m_code] = 1'b0;
            if (m_code == 6) pend[5] = 1'b0;
        end
        for (int i = 0; i < 5; i++)
            if (req[i]) pend[btn_code[i]] = 1'b1;
        if (tick) pend[5] = 1'b1;
        g_cnt = (!gravity_en || tick || m_code == 6) ? 0 : g_cnt + 1;
        for (int i = 0; i < 5; i++) begin
            old = acc[i];
            if (s2[i] != int'(acc[i])) begin
                run[i]++;
                if (run[i] == DB) begin
                    acc[i] = (s2[i] != 0);
                    run[i] = 0;
                end
            end else begin
                run[i] = 0;
            end
            age[i] = (acc[i] && old) ? age[i] + 1 : 0;
            s2[i]  = s1[i];
            s1[i]  = int'(btn[i]);
        end
        m_code = nxt;
        m_busy = (t + 1 < idle_at);
    endtask

    always @(posedge clk) begin
        if (!reset_n) model_reset();
        else          model_step(cyc);
        cyc++;
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_ctrl", ctrl, 0);
            check("rst_busy", busy, 0);
        end else begin
            check("ctrl", ctrl, m_code);
            check("busy", busy, m_busy);
        end
        if (ctrl != 3'd0) begin
            log_cyc.push_back(cyc);
            log_code.push_back(int'(ctrl));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int h;
        model_reset();
        reset_n = 1'b0; btn = '0; gravity_en = 1'b0; level = '0;
        step(3);
        check("reset_ctrl_lit", ctrl, 0);
        check("reset_busy_lit", busy, 0);
        reset_n = 1'b1;
        step(5);

        // single press of rotate
        t0 = cyc; btn[1] = 1'b1;
        step(7); check("press_before", ctrl, 0);
        step(1); check("press_code", ctrl, 2);
        check("press_busy", busy, 1);
        step(1); check("press_after", ctrl, 0);
        step(30); btn[1] = 1'b0;
        step(20);
        check("press_once", count_codes(2, t0, cyc - 1), 1);

        // bouncing left, then held with auto-repeat
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            btn[2] = (k % 2 == 0);
            step(2);
        end
        btn[2] = 1'b1; h = cyc;
        step(8);  check("bounce_first", ctrl, 3);
        step(20); check("repeat_first", ctrl, 3);
        step(10); check("repeat_second", ctrl, 3);
        check("bounce_single", count_codes(3, t0, h + 37), 2);
        step(32); btn[2] = 1'b0;
        step(40);

        // hold, right and hard drop together
        t0 = cyc; btn = 5'b11001;
        step(8);  check("simul_hold", ctrl, 1); btn = '0;
        step(10); check("simul_bar", ctrl, 6);
        step(10); check("simul_right", ctrl, 4);
        step(20);
        check("simul_count", count_codes(0, t0, cyc - 1), 3);

        // gravity at level 0, then speed-up mid-count
        t0 = cyc; gravity_en = 1'b1; level = 3'd0;
        step(65); check("grav_first", ctrl, 5);
        step(64); check("grav_second", ctrl, 5);
        step(19); level = 3'd3;
        step(2);  check("grav_level_up", ctrl, 5);
        step(10); check("grav_fast", ctrl, 5);
        gravity_en = 1'b0; level = 3'd0;
        step(30);

        // several gravity ticks during one gap merge into one DOWN
        t0 = cyc; btn[1] = 1'b1;
        step(8); check("merge_rotate", ctrl, 2); btn[1] = 1'b0;
        step(2); gravity_en = 1'b1; level = 3'd7;
        step(3); gravity_en = 1'b0; level = 3'd0;
        step(5); check("merge_down", ctrl, 5);
        step(20);
        check("merge_once", count_codes(5, t0, cyc - 1), 1);

        // reset while a code is on the bus
        t0 = cyc; btn[1] = 1'b1;
        step(8); check("rst_pre_code", ctrl, 2);
        btn[1] = 1'b0;
        #2 reset_n = 1'b0;
        #1 check("rst_async_ctrl", ctrl, 0);
        check("rst_async_busy", busy, 0);
        step(3); reset_n = 1'b1; t0 = cyc;
        step(40);
        check("rst_quiet", count_codes(0, t0, cyc - 1), 0);
        btn[0] = 1'b1;
        step(8); check("rst_new_press", ctrl, 1);
        btn[0] = 1'b0;
        step(20);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
